// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

endpackage

// File: rtl/muldiv_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift the quotient bit in.
module muldiv_div_iter #(
  parameter int Data_width = 32
) (
  input  logic [Data_width-1:0] rem_in,
  input  logic [Data_width-1:0] quo_in,
  input  logic [Data_width-1:0] divisor,
  output logic [Data_width-1:0] rem_out,
  output logic [Data_width-1:0] quo_out
);

  logic [Data_width:0] rem_sh;
  logic [Data_width:0] diff;
  logic                ge;

  always_comb begin
    rem_sh  = {rem_in, quo_in[Data_width-1]};
    diff    = rem_sh - {1'b0, divisor};
    // Partial remainder is always below the divisor, so bit Data_width is the borrow.
    ge      = ~diff[Data_width];
    rem_out = ge ? diff[Data_width-1:0] : rem_sh[Data_width-1:0];
    quo_out = {quo_in[Data_width-2:0], ge};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back handshake.
// Divide/remainder datapath is present only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Data_width    = XLEN,
  parameter int Address_width = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [Data_width-1:0]    operand_a,
  input  logic [Data_width-1:0]    operand_b,
  input  logic [Address_width-1:0] rd_addr,
  output logic                     busy,
  output logic                     done,
  output logic [Data_width-1:0]    result,
  output logic                     wb_en,
  output logic [Address_width-1:0] wb_addr
);

  localparam logic [Data_width-1:0] MIN_INT = {1'b1, {(Data_width-1){1'b0}}};

  state_e                   state_q, state_d;
  op_e                      op_q, op_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [Data_width-1:0]    hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic                     neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic                     busy_q, busy_d, done_q, done_d, wb_en_q, wb_en_d;
  logic [Data_width-1:0]    result_q, result_d;
  logic [Address_width-1:0] wb_addr_q, wb_addr_d;

  op_e                      op_in;
  logic                     a_signed, b_signed, neg_a, neg_b, special;
  logic [Data_width-1:0]    abs_a, abs_b, quo_fix, rem_fix;
  logic [Data_width:0]      mul_sum;
  logic [2*Data_width-1:0]  prod_fix;

`ifdef MULDIV_DIV_EN
  logic [Data_width-1:0] div_rem_nx, div_quo_nx;

  muldiv_div_iter #(.Data_width(Data_width)) u_div_iter (
    .rem_in  (hi_q),
    .quo_in  (lo_q),
    .divisor (b_q),
    .rem_out (div_rem_nx),
    .quo_out (div_quo_nx)
  );
`endif

  always_comb begin
    op_in    = op_e'(op);
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg_a    = a_signed & operand_a[Data_width-1];
    neg_b    = b_signed & operand_b[Data_width-1];
    abs_a    = neg_a ? (~operand_a + 1'b1) : operand_a;
    abs_b    = neg_b ? (~operand_b + 1'b1) : operand_b;
`ifdef MULDIV_DIV_EN
    special  = op_in[2] && ((operand_b == '0) ||
               (((op_in == OP_DIV) || (op_in == OP_REM)) && (operand_a == MIN_INT) && (operand_b == '1)));
`else
    special  = op_in[2];
`endif
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    prod_fix = neg_res_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    quo_fix  = neg_res_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // The done cycle is spent in IDLE; a start seen then waits one more cycle.
        if (start && !done_q) begin
          op_d      = op_in;
          wb_addr_d = rd_addr;
          cnt_d     = '0;
          busy_d    = 1'b1;
          b_d       = abs_b;
          hi_d      = '0;
          lo_d      = abs_a;
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          state_d   = S_CALC;
          if (special) begin
            state_d   = S_FIX;
            neg_res_d = 1'b0;
`ifdef MULDIV_DIV_EN
            // Preload so FIX yields quotient all-ones / remainder dividend, or the overflow pair.
            if (operand_b == '0) begin
              lo_d = DIV_ZERO_Q;
              hi_d = abs_a;
            end else begin
              lo_d      = MIN_INT;
              neg_rem_d = 1'b0;
            end
`else
            lo_d      = '0;
            neg_rem_d = 1'b0;
`endif
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
          hi_d = div_rem_nx;
          lo_d = div_quo_nx;
        end else
`endif
        begin
          hi_d = mul_sum[Data_width:1];
          lo_d = {mul_sum[0], lo_q[Data_width-1:1]};
        end
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        wb_en_d = (wb_addr_q != '0);
        state_d = S_IDLE;
        unique case (op_q)
          OP_MUL:                        result_d = prod_fix[Data_width-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*Data_width-1:Data_width];
          OP_DIV, OP_DIVU:               result_d = quo_fix;
          default:                       result_d = rem_fix;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_en   = wb_en_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit, plus hand-written multi-cycle
// sequences; expectations follow MULDIV_DIV_EN when it is defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_addr;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.Data_width(32), .Address_width(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Accept at the next posedge, then return the number of edges until done is seen (0 = timeout).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; rd_addr = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, k1, k2, ndone;
    logic [31:0] exp;
    string nm;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 33};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 33};
    vecs[6]  = '{3'd0, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 33};
    vecs[7]  = '{3'd4, 32'hFFFFFFD8, 32'h00000002, 5'd11, 32'hFFFFFFEC, 33};
    vecs[8]  = '{3'd6, 32'hFFFFFFD7, 32'h00000002, 5'd12, 32'hFFFFFFFF, 33};
    vecs[9]  = '{3'd5, 32'h00000028, 32'h00000000, 5'd13, 32'hFFFFFFFF, 1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1};
    vecs[12] = '{3'd5, 32'd100,      32'd7,        5'd16, 32'd14,       33};
    vecs[13] = '{3'd7, 32'd100,      32'd7,        5'd17, 32'd2,        33};
    vecs[14] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 5'd18, 32'hFFFFFFF9, 1};
    vecs[15] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 33};
    vecs[16] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 5'd0,  32'h00000001, 33};

    rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      exp = vecs[i].exp;
      k1  = vecs[i].lat;
`ifndef MULDIV_DIV_EN
      if (vecs[i].op[2]) begin
        exp = 32'd0;
        k1  = 1;
      end
`endif
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
      nm = $sformatf("v%0d", i);
      chk({nm, "_latency"}, lat, k1);
      chk({nm, "_result"}, result, exp);
      chk({nm, "_wb_en"}, {31'd0, wb_en}, {31'd0, (vecs[i].rd != 5'd0)});
      chk({nm, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, vecs[i].rd});
      chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      chk({nm, "_done_drop"}, {31'd0, done}, 32'd0);
      chk({nm, "_busy_drop"}, {31'd0, busy}, 32'd0);
      chk({nm, "_result_hold"}, result, exp);
    end

    // start while busy must be ignored and never queued
    @(negedge clk);
    start = 1'b1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd4; rd_addr = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    k1 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 3'd3; operand_a = '1; operand_b = '1; rd_addr = 5'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        k1 = k;
        break;
      end
    end
    start = 1'b0;
    chk("ignore_latency", k1, 33);
    chk("ignore_result", result, 32'd12);
    chk("ignore_wb_addr", {27'd0, wb_addr}, 32'd2);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("ignore_no_queue", ndone, 0);

    // start held through the done cycle: next accept is one cycle later
    @(negedge clk);
    start = 1'b1; op = 3'd0; operand_a = 32'd2; operand_b = 32'd3; rd_addr = 5'd3;
    @(posedge clk);
    #1;
    k1 = 0; k2 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 34) chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
      if (done && k1 == 0) k1 = k;
      else if (done) begin
        k2 = k;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_first", k1, 33);
    chk("b2b_second", k2, 68);
    chk("b2b_result", result, 32'd6);
    repeat (40) @(posedge clk);

    // reset during CALC discards the operation
    @(negedge clk);
    start = 1'b1; op = 3'd0; operand_a = 32'd5; operand_b = 32'd5; rd_addr = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_wb_addr", {27'd0, wb_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("midrst_quiet", ndone, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of `Registry_file` read ports (DataA/DataB) and upstream of its write port. It captures two 32-bit operands on a start pulse, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles while stalling the core via `busy`, then presents a one-cycle write-back (`wb_en`, `wb_addr`, `result`) aligned to `Write_data`/`DataWrite_addr`/`write_en`.

## Interface
- Data_width, 32, operand/result width (only 32 supported)
- Address_width, 5, destination register address width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a  in  Data_width  rs1 value (from DataA)
- operand_b  in  Data_width  rs2 value (from DataB)
- rd_addr  in  Address_width  destination register
- busy  out  1  high from accept until write-back cycle inclusive
- done  out  1  one-cycle pulse, result valid
- result  out  Data_width  final value; held until next accept
- wb_en  out  1  = done && (wb_addr != 0)
- wb_addr  out  Address_width  captured rd_addr

## Operation
- States: IDLE, CALC, FIX. Reset -> IDLE; busy=0, done=0, wb_en=0, result=0, wb_addr=0, counter=0.
- IDLE & start: latch op, rd_addr, |a|, |b| (signedness per op), result sign flags; counter=0; -> CALC. Otherwise stay.
- Special cases bypass CALC (IDLE -> FIX directly): divisor 0 (DIV/DIVU quotient = 0xFFFFFFFF, REM/REMU remainder = dividend); DIV overflow 0x80000000 / 0xFFFFFFFF (quotient 0x80000000, REM 0).
- CALC multiply: 64-bit shift-add, one multiplier bit per cycle, 32 cycles.
- CALC divide: restoring, one quotient bit per cycle, 32 cycles; 33-bit trial subtract.
- counter 5 bits; CALC exits to FIX when counter==31 after that iteration (no wrap issue).
- FIX: apply sign correction (two's complement of 64-bit product if signs differ; quotient negated if signs differ; remainder takes dividend sign); select low/high word; load result, done=1, wb_en per rd_addr; -> IDLE.
- start while busy: ignored, no queuing.
- start in the same cycle as done (back-to-back): done cycle is already IDLE-bound; start sampled the following cycle.
- rst mid-operation: everything returns to reset values next edge; in-flight op discarded, no done.

## Timing
- Accept at edge N. Normal ops: done/wb_en high in cycle after edge N+33 (latency 34), busy high cycles N+1..N+34 edges exclusive of the last? Precisely: busy=1 from edge N through edge N+34; done=1 only between edges N+33 and N+34.
- Special cases: done between edges N+1 and N+2.
- Outputs registered; no combinational path input -> output.
- Write-back consumed by register file on its negedge within the done cycle.

## Configuration
- MULDIV_DIV_EN defined: full divide/remainder support as above.
- Undefined: divider datapath removed; ops 4-7 take the bypass path, result=0, done after 2 cycles, wb_en as normal. Multiply unchanged.

## Structure
- Package `muldiv_pkg`: op enum (funct3 encodings), state enum {IDLE, CALC, FIX}, XLEN=32, DIV_ZERO_Q constant.
- Sub-module `muldiv_div_iter`: one restoring-division step (remainder/quotient shift and trial subtract), instantiated only under MULDIV_DIV_EN.

## Test plan
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5 -> done at edge N+33, result 0xFFFFFFEB, wb_en=1, wb_addr=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
- DIV -40 / 2 -> 0xFFFFFFEC; REM -41 / 2 -> 0xFFFFFFFF; DIVU 40/0 -> 0xFFFFFFFF after 2 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, latency 2.
- rst asserted at CALC cycle 10 -> next edge busy=0, done never pulses; start during busy ignored; rd=0 -> done=1, wb_en=0.
